// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT butterfly scheduler and butterfly unit.
package fft_pkg;

    localparam int FFT_LOG2N  = 4;
    localparam int FFT_ADDR_W = FFT_LOG2N;
    localparam int FFT_TW_W   = FFT_LOG2N - 1;
    localparam int FFT_STG_W  = (FFT_LOG2N > 1) ? $clog2(FFT_LOG2N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    // One butterfly request as carried from the scheduler to the butterfly unit.
    typedef struct packed {
        logic [FFT_ADDR_W-1:0] top;
        logic [FFT_ADDR_W-1:0] bot;
        logic [FFT_TW_W-1:0]   tw;
        logic [FFT_STG_W-1:0]  stage;
        logic                  last;
    } bfly_req_t;

endpackage

// File: rtl/fft_bfly_sched_if.sv
// Butterfly request/completion channel between the scheduler and the butterfly unit.
interface fft_bfly_sched_if #(
    parameter int ADDR_W = 4,
    parameter int TW_W   = 3,
    parameter int STG_W  = 2
);

    logic              bf_valid;
    logic              bf_ready;
    logic [ADDR_W-1:0] bf_top;
    logic [ADDR_W-1:0] bf_bot;
    logic [TW_W-1:0]   bf_tw;
    logic [STG_W-1:0]  bf_stage;
    logic              bf_last;
    logic              cmp_valid;

    modport master (
        output bf_valid, bf_top, bf_bot, bf_tw, bf_stage, bf_last,
        input  bf_ready, cmp_valid
    );

    modport slave (
        input  bf_valid, bf_top, bf_bot, bf_tw, bf_stage, bf_last,
        output bf_ready, cmp_valid
    );

endinterface

// File: rtl/fft_bfly_addr_gen.sv
// Maps (stage s, butterfly k) to operand indices, twiddle index and last-of-stage flag.
module fft_bfly_addr_gen #(
    parameter int LOG2N  = 4,
    parameter int ADDR_W = LOG2N,
    parameter int TW_W   = LOG2N - 1,
    parameter int STG_W  = 2
) (
    input  logic [STG_W-1:0]  s,
    input  logic [TW_W-1:0]   k,
    output logic [ADDR_W-1:0] top,
    output logic [ADDR_W-1:0] bot,
    output logic [TW_W-1:0]   tw,
    output logic              last
);

    localparam logic [TW_W-1:0] K_LAST = TW_W'((1 << (LOG2N - 1)) - 1);

    logic [ADDR_W-1:0] kw;
    logic [ADDR_W-1:0] half;
    logic [ADDR_W-1:0] low;

    // Group index k>>s is spread by 2*half; the position inside the group stays in place.
    always_comb begin
        kw   = ADDR_W'(k);
        half = ADDR_W'(1) << s;
        low  = kw & (half - ADDR_W'(1));
        top  = (((kw >> s) << 1) << s) | low;
        bot  = top + half;
        tw   = TW_W'(low << (LOG2N - 1 - int'(s)));
        last = (k == K_LAST);
    end

endmodule

// File: rtl/fft_bfly_sched.sv
// Stage-by-stage butterfly issue sequencer with in-flight throttling and a stage barrier.
module fft_bfly_sched
    import fft_pkg::*;
#(
    parameter int LOG2N   = FFT_LOG2N,
    parameter int MAX_OUT = 4,
    parameter int ADDR_W  = LOG2N,
    parameter int TW_W    = LOG2N - 1
) (
    input  logic             Clock,
    input  logic             Areset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             cmp_err,
    fft_bfly_sched_if.master bf
);

    localparam int STG_W = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    localparam logic [TW_W-1:0]  K_LAST  = TW_W'((1 << (LOG2N - 1)) - 1);
    localparam logic [STG_W-1:0] S_LAST  = STG_W'(LOG2N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    state_t            state;
    logic [STG_W-1:0]  s;
    logic [TW_W-1:0]   k;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              issuing;
    logic              xfer;
    logic              retire;
    logic [ADDR_W-1:0] top;
    logic [ADDR_W-1:0] bot;
    logic [TW_W-1:0]   tw;
    logic              last;

    fft_bfly_addr_gen #(
        .LOG2N (LOG2N),
        .ADDR_W(ADDR_W),
        .TW_W  (TW_W),
        .STG_W (STG_W)
    ) u_addr_gen (
        .s   (s),
        .k   (k),
        .top (top),
        .bot (bot),
        .tw  (tw),
        .last(last)
    );

    assign issuing = (state == ISSUE);
    assign xfer    = bf.bf_valid && bf.bf_ready;
    assign retire  = bf.cmp_valid && (count != '0);

    // Payload is forced to zero outside ISSUE so an idle or reset scheduler shows all-zero outputs.
    assign bf.bf_valid = issuing && (count < CNT_MAX);
    assign bf.bf_top   = issuing ? top : '0;
    assign bf.bf_bot   = issuing ? bot : '0;
    assign bf.bf_tw    = issuing ? tw : '0;
    assign bf.bf_stage = issuing ? s : '0;
    assign bf.bf_last  = issuing && last;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        count_next = count;
        if (xfer && !retire) begin
            count_next = count + CNT_W'(1);
        end else if (!xfer && retire) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Areset) begin
            state   <= IDLE;
            s       <= '0;
            k       <= '0;
            count   <= '0;
            cmp_err <= 1'b0;
        end else begin
            count <= count_next;
            if (bf.cmp_valid && (count == '0)) begin
                cmp_err <= 1'b1;
            end else if ((state == IDLE) && start) begin
                cmp_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        s     <= '0;
                        k     <= '0;
                    end
                end
                ISSUE: begin
                    if (xfer) begin
                        if (k == K_LAST) begin
                            state <= DRAIN;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                // The next stage may only start once every outstanding butterfly has written back.
                DRAIN: begin
                    if (count_next == '0) begin
                        if (s == S_LAST) begin
                            state <= DONE;
                        end else begin
                            s     <= s + 1'b1;
                            k     <= '0;
                            state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Scoreboard bench for fft_bfly_sched with a delayed-completion butterfly model.
`timescale 1ns/1ps
module tb_fft_bfly_sched;
    import fft_pkg::*;

    localparam int N       = 1 << FFT_LOG2N;
    localparam int MAX_OUT = 4;

    logic Clock = 1'b0;
    logic Areset;
    logic start;
    logic busy;
    logic done;
    logic cmp_err;

    fft_bfly_sched_if #(.ADDR_W(FFT_ADDR_W), .TW_W(FFT_TW_W), .STG_W(FFT_STG_W)) bf_if ();

    fft_bfly_sched #(.LOG2N(FFT_LOG2N), .MAX_OUT(MAX_OUT)) dut (
        .Clock  (Clock),
        .Areset (Areset),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .cmp_err(cmp_err),
        .bf     (bf_if)
    );

    logic [FFT_STG_W-1:0]  ag_s;
    logic [FFT_TW_W-1:0]   ag_k;
    logic [FFT_ADDR_W-1:0] ag_top;
    logic [FFT_ADDR_W-1:0] ag_bot;
    logic [FFT_TW_W-1:0]   ag_tw;
    logic                  ag_last;

    fft_bfly_addr_gen #(.LOG2N(FFT_LOG2N), .ADDR_W(FFT_ADDR_W), .TW_W(FFT_TW_W), .STG_W(FFT_STG_W)) u_ag (
        .s(ag_s), .k(ag_k), .top(ag_top), .bot(ag_bot), .tw(ag_tw), .last(ag_last)
    );

    int        check_count = 0;
    int        error_count = 0;
    bfly_req_t sb_q[$];
    int        due_q[$];
    int        cyc = 0;
    int        cmp_delay = 1;
    bit        cmp_auto = 1'b1;
    bit        cmp_manual = 1'b0;
    bit        ready_toggle = 1'b0;
    int        xfer_count = 0;
    int        done_count = 0;
    int        outstanding = 0;
    int        last_stage = 0;
    bit        prev_stall = 1'b0;
    bfly_req_t prev_req;

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Butterfly unit model: ready pattern 1,0,0,1 when toggling; completions cmp_delay cycles after accept.
    always @(negedge Clock) begin
        #1;
        bf_if.bf_ready = ready_toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        if (cmp_manual) begin
            bf_if.cmp_valid = 1'b1;
        end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            bf_if.cmp_valid = 1'b1;
        end else begin
            bf_if.cmp_valid = 1'b0;
        end
    end

    always @(negedge Clock) begin
        bfly_req_t cur;
        bfly_req_t exp_r;
        #4;
        cur.top   = bf_if.bf_top;
        cur.bot   = bf_if.bf_bot;
        cur.tw    = bf_if.bf_tw;
        cur.stage = bf_if.bf_stage;
        cur.last  = bf_if.bf_last;
        if (done) done_count++;
        if (Areset) begin
            if (prev_stall) begin
                checkOutput("holdValid", 32'(bf_if.bf_valid), 32'd1);
                if (bf_if.bf_valid) checkOutput("holdReq", 32'(cur), 32'(prev_req));
            end
            if (bf_if.bf_valid && bf_if.bf_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("sbEmpty", 32'd1, 32'd0);
                end else begin
                    exp_r = sb_q.pop_front();
                    checkOutput("top", 32'(cur.top), 32'(exp_r.top));
                    checkOutput("bot", 32'(cur.bot), 32'(exp_r.bot));
                    checkOutput("tw", 32'(cur.tw), 32'(exp_r.tw));
                    checkOutput("stage", 32'(cur.stage), 32'(exp_r.stage));
                    checkOutput("last", 32'(cur.last), 32'(exp_r.last));
                end
                if (int'(cur.stage) != last_stage) checkOutput("barrier", 32'(outstanding), 32'd0);
                last_stage = int'(cur.stage);
                xfer_count++;
                if (cmp_auto) due_q.push_back(cyc + cmp_delay);
            end
            if (bf_if.cmp_valid && outstanding > 0) outstanding--;
            if (bf_if.bf_valid && bf_if.bf_ready) begin
                outstanding++;
                checkOutput("inflight", 32'(outstanding <= MAX_OUT), 32'd1);
            end
            prev_stall = bf_if.bf_valid && !bf_if.bf_ready;
            prev_req   = cur;
        end else begin
            prev_stall  = 1'b0;
            outstanding = 0;
        end
    end

    // Loads the expected order of all butterflies, enumerated by group and offset, then raises start.
    task automatic applyStimulus();
        bfly_req_t r;
        sb_q.delete();
        for (int st = 0; st < FFT_LOG2N; st++) begin
            int half;
            int groups;
            half   = 1 << st;
            groups = N / (2 * half);
            for (int g = 0; g < groups; g++) begin
                for (int j = 0; j < half; j++) begin
                    r.top   = FFT_ADDR_W'(g * 2 * half + j);
                    r.bot   = FFT_ADDR_W'(g * 2 * half + j + half);
                    r.tw    = FFT_TW_W'(j * groups);
                    r.stage = FFT_STG_W'(st);
                    r.last  = (g == groups - 1) && (j == half - 1);
                    sb_q.push_back(r);
                end
            end
        end
        @(negedge Clock);
        xfer_count = 0;
        done_count = 0;
        last_stage = 0;
        start      = 1'b1;
    endtask

    task automatic waitDone(input int bound, input bit hold_start, output int cycles);
        cycles = -1;
        for (int n = 1; n <= bound; n++) begin
            @(negedge Clock);
            if (!hold_start) start = 1'b0;
            if (done) begin
                cycles = n;
                start  = 1'b0;
                break;
            end
        end
        checkOutput("doneSeen", 32'(cycles > 0), 32'd1);
    endtask

    task automatic checkRunEnd(input string tag);
        repeat (4) @(negedge Clock);
        checkOutput({tag, "Xfers"}, 32'(xfer_count), 32'd32);
        checkOutput({tag, "SbLeft"}, 32'(sb_q.size()), 32'd0);
        checkOutput({tag, "DoneCnt"}, 32'(done_count), 32'd1);
        checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "Done"}, 32'(done), 32'd0);
        checkOutput({tag, "Valid"}, 32'(bf_if.bf_valid), 32'd0);
        checkOutput({tag, "Top"}, 32'(bf_if.bf_top), 32'd0);
        checkOutput({tag, "Bot"}, 32'(bf_if.bf_bot), 32'd0);
        checkOutput({tag, "Tw"}, 32'(bf_if.bf_tw), 32'd0);
        checkOutput({tag, "Stage"}, 32'(bf_if.bf_stage), 32'd0);
        checkOutput({tag, "Last"}, 32'(bf_if.bf_last), 32'd0);
        checkOutput({tag, "Err"}, 32'(cmp_err), 32'd0);
    endtask

    initial begin
        int cycles;
        Areset = 1'b0;
        start  = 1'b0;
        repeat (3) @(negedge Clock);
        checkAllZero("reset");
        Areset = 1'b1;

        // Address generator spot checks, including the last-of-stage flag across stage 0.
        ag_s = 2'd1; ag_k = 3'd1; #1;
        checkOutput("agTop11", 32'(ag_top), 32'd1);
        checkOutput("agBot11", 32'(ag_bot), 32'd3);
        checkOutput("agTw11", 32'(ag_tw), 32'd4);
        ag_k = 3'd2; #1;
        checkOutput("agTop12", 32'(ag_top), 32'd4);
        checkOutput("agBot12", 32'(ag_bot), 32'd6);
        checkOutput("agTw12", 32'(ag_tw), 32'd0);
        ag_s = 2'd3; ag_k = 3'd5; #1;
        checkOutput("agTop35", 32'(ag_top), 32'd5);
        checkOutput("agBot35", 32'(ag_bot), 32'd13);
        checkOutput("agTw35", 32'(ag_tw), 32'd5);
        ag_s = 2'd0;
        for (int kk = 0; kk < N / 2; kk++) begin
            ag_k = 3'(kk); #1;
            checkOutput("agLast", 32'(ag_last), 32'(kk == N / 2 - 1));
        end

        applyStimulus();
        waitDone(200, 1'b0, cycles);
        checkOutput("doneLatency", 32'(cycles), 32'd37);
        @(negedge Clock);
        checkOutput("busyAfterDone", 32'(busy), 32'd0);
        checkRunEnd("free");

        ready_toggle = 1'b1;
        applyStimulus();
        waitDone(400, 1'b0, cycles);
        ready_toggle = 1'b0;
        checkRunEnd("bp");

        cmp_auto = 1'b0;
        applyStimulus();
        @(negedge Clock);
        start = 1'b0;
        repeat (30) @(negedge Clock);
        checkOutput("thrXfers", 32'(xfer_count), 32'd4);
        checkOutput("thrValid", 32'(bf_if.bf_valid), 32'd0);
        checkOutput("thrBusy", 32'(busy), 32'd1);
        cmp_manual = 1'b1;
        @(negedge Clock);
        cmp_manual = 1'b0;
        repeat (10) @(negedge Clock);
        checkOutput("thrXfers2", 32'(xfer_count), 32'd5);
        checkOutput("thrValid2", 32'(bf_if.bf_valid), 32'd0);
        Areset = 1'b0;
        due_q.delete();
        @(negedge Clock);
        Areset   = 1'b1;
        cmp_auto = 1'b1;
        sb_q.delete();

        cmp_delay = 10;
        applyStimulus();
        waitDone(2000, 1'b0, cycles);
        cmp_delay = 1;
        checkRunEnd("slow");

        @(negedge Clock);
        cmp_manual = 1'b1;
        @(negedge Clock);
        cmp_manual = 1'b0;
        checkOutput("cmpErrSet", 32'(cmp_err), 32'd1);
        applyStimulus();
        @(negedge Clock);
        start = 1'b0;
        checkOutput("cmpErrClear", 32'(cmp_err), 32'd0);
        waitDone(200, 1'b0, cycles);
        checkRunEnd("err");

        applyStimulus();
        cycles = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge Clock);
            start = 1'b0;
            if (bf_if.bf_valid && bf_if.bf_stage == 2'd2) begin
                cycles = 1;
                break;
            end
        end
        checkOutput("reachStage2", 32'(cycles), 32'd1);
        Areset = 1'b0;
        due_q.delete();
        @(negedge Clock);
        checkAllZero("midRst");
        Areset = 1'b1;
        sb_q.delete();
        applyStimulus();
        waitDone(200, 1'b0, cycles);
        checkRunEnd("restart");

        applyStimulus();
        waitDone(200, 1'b1, cycles);
        checkRunEnd("hold");

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
